// File: rtl/rs_encoder_204_188.sv
// Systematic RS(204,188,T=8) encoder over GF(2^8): 188 message bytes pass through, then 16 parity bytes.
// Latency: 1 cycle from accepted message byte to Enc_Out; parity follows in 16 consecutive active cycles.
// Backpressure: In_Ready drops during the 16 parity cycles; CS=0 freezes all state and forces Out_Valid=0.
//
// Ports:
//   Clk, Reset     rising-edge clock, asynchronous active-low reset
//   CS             chip select; 0 pauses the encoder exactly where it is
//   Msg_In/In_Valid/In_Ready   message byte input with valid/ready handshake
//   Enc_Out/Out_Valid/Out_Sop/Out_Eop   registered codeword byte stream with frame markers

module rs_encoder_204_188 #(
    parameter int         N       = 204,
    parameter int         K       = 188,
    parameter logic [8:0] GF_POLY = 9'h11D
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       CS,
    input  logic [7:0] Msg_In,
    input  logic       In_Valid,
    output logic       In_Ready,
    output logic [7:0] Enc_Out,
    output logic       Out_Valid,
    output logic       Out_Sop,
    output logic       Out_Eop
);

    // Last message-byte index and last parity-byte index, as count values.
    localparam logic [7:0] LAST_MSG = 8'(K - 1);
    localparam logic [7:0] LAST_PAR = 8'(N - K - 1);

    // GF(2^8) multiply, shift-and-add with reduction by the field polynomial.
    // With one operand constant this collapses to a pure XOR network.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] sh;
        acc = 8'h00;
        sh  = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) begin
                acc = acc ^ sh;
            end
            sh = sh[7] ? ({sh[6:0], 1'b0} ^ GF_POLY[7:0]) : {sh[6:0], 1'b0};
        end
        return acc;
    endfunction

    // Generator g(x) = prod_{i=0..15} (x + alpha^i), alpha = 0x02.
    // Returns g0..g15; the x^16 coefficient is 1 and implicit.
    function automatic logic [15:0][7:0] gen_poly();
        logic [16:0][7:0] g;
        logic [7:0]       root;
        g    = '0;
        g[0] = 8'h01;
        root = 8'h01;
        for (int i = 0; i < 16; i++) begin
            // multiply running product by (x + root)
            for (int k = 16; k >= 1; k--) begin
                g[k] = g[k-1] ^ gf_mul(g[k], root);
            end
            g[0] = gf_mul(g[0], root);
            root = gf_mul(root, 8'h02);
        end
        return g[15:0];
    endfunction

    localparam logic [15:0][7:0] G = gen_poly();

    typedef enum logic {
        S_MSG = 1'b0,
        S_PAR = 1'b1
    } state_t;

    state_t           state;
    logic [7:0]       count;
    logic [15:0][7:0] p;

    logic [7:0]       fb;
    logic [15:0][7:0] p_msg;

    // Ready is a decode of registered state gated by chip select only;
    // it never depends on In_Valid.
    assign In_Ready = CS && (state == S_MSG);

    // Next parity register contents when a message byte is absorbed:
    // remainder LFSR in Galois form, feedback = incoming byte ^ top stage.
    always_comb begin
        fb       = Msg_In ^ p[15];
        p_msg[0] = gf_mul(fb, G[0]);
        for (int i = 1; i < 16; i++) begin
            p_msg[i] = p[i-1] ^ gf_mul(fb, G[i]);
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state     <= S_MSG;
            count     <= 8'd0;
            p         <= '0;
            Enc_Out   <= 8'h00;
            Out_Valid <= 1'b0;
            Out_Sop   <= 1'b0;
            Out_Eop   <= 1'b0;
        end else if (!CS) begin
            // Paused: everything holds except the strobes.
            Out_Valid <= 1'b0;
            Out_Sop   <= 1'b0;
            Out_Eop   <= 1'b0;
        end else begin
            case (state)
                S_MSG: begin
                    // CS=1 and MSG state means In_Ready=1, so In_Valid alone
                    // decides whether a byte is accepted.
                    if (In_Valid) begin
                        p         <= p_msg;
                        Enc_Out   <= Msg_In;
                        Out_Valid <= 1'b1;
                        Out_Sop   <= (count == 8'd0);
                        Out_Eop   <= 1'b0;
                        if (count == LAST_MSG) begin
                            count <= 8'd0;
                            state <= S_PAR;
                        end else begin
                            count <= count + 8'd1;
                        end
                    end else begin
                        Out_Valid <= 1'b0;
                        Out_Sop   <= 1'b0;
                        Out_Eop   <= 1'b0;
                    end
                end
                S_PAR: begin
                    // Highest-degree remainder coefficient goes out first;
                    // shifting zeros in leaves p all-zero after 16 cycles.
                    Enc_Out   <= p[15];
                    Out_Valid <= 1'b1;
                    Out_Sop   <= 1'b0;
                    p         <= {p[14:0], 8'h00};
                    if (count == LAST_PAR) begin
                        Out_Eop <= 1'b1;
                        count   <= 8'd0;
                        state   <= S_MSG;
                    end else begin
                        Out_Eop <= 1'b0;
                        count   <= count + 8'd1;
                    end
                end
                default: begin
                    state <= S_MSG;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rs_encoder_204_188.sv
// Scoreboard bench for rs_encoder_204_188: a long-division RS reference model
// fills an expected-byte queue per packet; a negedge monitor pops and compares.
module tb_rs_encoder_204_188;

    logic       Clk = 1'b0;
    logic       Reset = 1'b0;
    logic       CS = 1'b0;
    logic [7:0] Msg_In = 8'h00;
    logic       In_Valid = 1'b0;
    logic       In_Ready;
    logic [7:0] Enc_Out;
    logic       Out_Valid;
    logic       Out_Sop;
    logic       Out_Eop;

    rs_encoder_204_188 dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .CS       (CS),
        .Msg_In   (Msg_In),
        .In_Valid (In_Valid),
        .In_Ready (In_Ready),
        .Enc_Out  (Enc_Out),
        .Out_Valid(Out_Valid),
        .Out_Sop  (Out_Sop),
        .Out_Eop  (Out_Eop)
    );

    always #5 Clk = ~Clk;

    int total = 0;
    int bad   = 0;

    // expected entries: {sop, eop, byte}
    logic [9:0] sb[$];

    int gexp[0:254];
    int glog[0:255];
    int gen[0:16];   // gen[k] = coefficient of x^k, gen[16] = 1

    int run_len = 0;
    int max_run = 0;

    logic [7:0] cap[0:203];
    int         cap_len = 0;

    logic [7:0] pkt_a[0:187];
    logic [7:0] pkt_b[0:187];
    logic [7:0] pkt_r[0:187];

    task automatic chk(input string name, input int act, input int exp_v);
        total++;
        if (act != exp_v) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp_v, $time);
        end
    endtask

    function automatic int gmul(input int a, input int b);
        if (a == 0 || b == 0) return 0;
        return gexp[(glog[a] + glog[b]) % 255];
    endfunction

    task automatic build_tables();
        int v;
        v = 1;
        for (int i = 0; i < 255; i++) begin
            gexp[i] = v;
            glog[v] = i;
            v = v << 1;
            if (v > 255) v = v ^ 'h11D;
        end
        glog[0] = 0;
        for (int k = 0; k <= 16; k++) gen[k] = 0;
        gen[0] = 1;
        for (int i = 0; i < 16; i++) begin
            for (int k = 16; k >= 1; k--) gen[k] = gen[k-1] ^ gmul(gen[k], gexp[i]);
            gen[0] = gmul(gen[0], gexp[i]);
        end
    endtask

    // Number of nonzero syndromes, evaluating the codeword polynomial at
    // alpha^0..alpha^15 (byte 0 is the highest-degree coefficient).
    function automatic int syn_nonzero(input logic [7:0] cw[0:203]);
        int n;
        int s;
        n = 0;
        for (int i = 0; i < 16; i++) begin
            s = 0;
            for (int j = 0; j < 204; j++) s = gmul(s, gexp[i]) ^ int'(cw[j]);
            if (s != 0) n++;
        end
        return n;
    endfunction

    // Reference codeword via polynomial long division of m(x)*x^16 by g(x).
    task automatic push_expected(input logic [7:0] m[0:187]);
        int d[0:203];
        int c;
        for (int i = 0; i < 204; i++) d[i] = (i < 188) ? int'(m[i]) : 0;
        for (int i = 0; i < 188; i++) begin
            c = d[i];
            for (int j = 0; j <= 16; j++) d[i+j] = d[i+j] ^ gmul(c, gen[16-j]);
        end
        for (int i = 0; i < 204; i++) begin
            sb.push_back({(i == 0), (i == 203), (i < 188) ? m[i] : 8'(d[i])});
        end
    endtask

    task automatic send_packet(input logic [7:0] m[0:187], input int stop, input bit gaps,
                               input bit pulses, output int stalls);
        int  idx;
        int  cyc;
        bit  lat_pending;
        idx = 0;
        cyc = 0;
        lat_pending = 1'b0;
        stalls = 0;
        push_expected(m);
        while (idx < stop && cyc < 5000) begin
            @(posedge Clk);
            #1;
            if (lat_pending) begin
                chk("first_byte_latency", {30'd0, Out_Valid, Out_Sop}, 3);
                lat_pending = 1'b0;
            end
            CS       = pulses ? ($urandom_range(0, 7) != 0) : 1'b1;
            In_Valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            Msg_In   = m[idx];
            #1;
            if (In_Valid && CS && !In_Ready) stalls++;
            if (In_Valid && In_Ready) begin
                if (idx == 0) lat_pending = 1'b1;
                idx++;
            end
            cyc++;
        end
        if (cyc >= 5000) chk("send_timeout", idx, stop);
    endtask

    task automatic drain(input bit pulses);
        int cyc;
        cyc = 0;
        while (sb.size() > 0 && cyc < 1000) begin
            @(posedge Clk);
            #1;
            CS       = pulses ? ($urandom_range(0, 3) != 0) : 1'b1;
            In_Valid = 1'b0;
            cyc++;
        end
        chk("drain_queue_empty", sb.size(), 0);
        CS = 1'b1;
        repeat (3) @(posedge Clk);
        #1;
    endtask

    // Monitor / scoreboard
    always @(negedge Clk) begin
        logic [9:0] e;
        logic [7:0] tmp[0:203];
        int         k;
        if ((Out_Sop || Out_Eop) && !Out_Valid) begin
            total++;
            bad++;
            $display("FAIL marker_without_valid sop=%0b eop=%0b at %0t", Out_Sop, Out_Eop, $time);
        end
        if (Out_Valid) begin
            run_len++;
            if (run_len > max_run) max_run = run_len;
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_output byte=%0h at %0t", Enc_Out, $time);
            end else begin
                e = sb.pop_front();
                chk("codeword_byte", int'({Out_Sop, Out_Eop, Enc_Out}), int'(e));
            end
            if (Out_Sop) cap_len = 0;
            if (cap_len < 204) cap[cap_len] = Enc_Out;
            cap_len++;
            if (Out_Eop) begin
                chk("codeword_length", cap_len, 204);
                if (cap_len == 204) begin
                    chk("syndromes_zero", syn_nonzero(cap), 0);
                    tmp = cap;
                    k = $urandom_range(0, 203);
                    tmp[k] = tmp[k] ^ 8'($urandom_range(1, 255));
                    total++;
                    if (syn_nonzero(tmp) == 0) begin
                        bad++;
                        $display("FAIL flipped_byte_syndromes actual=0 expected=nonzero idx=%0d", k);
                    end
                end
            end
        end else begin
            run_len = 0;
        end
    end

    initial begin
        int st;
        build_tables();
        for (int i = 0; i < 188; i++) begin
            pkt_a[i] = 8'($urandom_range(0, 255));
            pkt_b[i] = 8'($urandom_range(0, 255));
            pkt_r[i] = 8'($urandom_range(0, 255));
        end

        // Reset state
        repeat (3) @(posedge Clk);
        #1;
        chk("reset_out_valid", int'(Out_Valid), 0);
        chk("reset_enc_out", int'(Enc_Out), 0);
        chk("reset_sop_eop", int'({Out_Sop, Out_Eop}), 0);
        chk("reset_in_ready_cs0", int'(In_Ready), 0);
        CS = 1'b1;
        #1;
        chk("reset_in_ready_cs1", int'(In_Ready), 1);
        Reset = 1'b1;

        // 1: all-zero packet, continuous
        for (int i = 0; i < 188; i++) pkt_r[i] = 8'h00;
        max_run = 0;
        send_packet(pkt_r, 188, 1'b0, 1'b0, st);
        drain(1'b0);
        chk("zero_pkt_valid_run", max_run, 204);
        chk("zero_pkt_stalls", st, 0);

        // 2: single 0x01 in the last message byte -> parity = g15..g0
        pkt_r[187] = 8'h01;
        send_packet(pkt_r, 188, 1'b0, 1'b0, st);
        drain(1'b0);

        // 3: random packet
        send_packet(pkt_a, 188, 1'b0, 1'b0, st);
        drain(1'b0);

        // 4: two packets back-to-back
        max_run = 0;
        send_packet(pkt_a, 188, 1'b0, 1'b0, st);
        chk("b2b_first_stalls", st, 0);
        send_packet(pkt_b, 188, 1'b0, 1'b0, st);
        chk("b2b_ready_low_cycles", st, 16);
        drain(1'b0);
        chk("b2b_valid_run", max_run, 408);

        // 5: same packet with In_Valid gaps and CS pulses, including in PAR
        send_packet(pkt_a, 188, 1'b1, 1'b1, st);
        drain(1'b1);
        send_packet(pkt_b, 188, 1'b1, 1'b1, st);
        drain(1'b1);

        // 6: reset partway through a packet, then a fresh one
        send_packet(pkt_b, 100, 1'b0, 1'b0, st);
        Reset = 1'b0;
        #1;
        chk("async_reset_out_valid", int'(Out_Valid), 0);
        chk("async_reset_enc_out", int'(Enc_Out), 0);
        chk("async_reset_sop_eop", int'({Out_Sop, Out_Eop}), 0);
        sb.delete();
        In_Valid = 1'b0;
        @(posedge Clk);
        #1;
        Reset = 1'b1;
        for (int i = 0; i < 188; i++) pkt_r[i] = 8'($urandom_range(0, 255));
        send_packet(pkt_r, 188, 1'b0, 1'b0, st);
        drain(1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
